// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : constants and FSM state type shared by the UART paths
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  localparam int UART_WORD_SIZE    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_if : serial line plus host-side valid/ack receive port
// Rev 1.0
// ------------------------------------------------------------------
interface uart_rx_if import uart_pkg::*; #(
  parameter int WORD_SIZE = UART_WORD_SIZE
) ();

  logic                 serial_in;
  logic                 rx_ack;
  logic [WORD_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 framing_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output serial_in, rx_ack,
    input  rx_data, rx_valid, framing_err, overrun_err, busy
  );

  modport slave (
    input  serial_in, rx_ack,
    output rx_data, rx_valid, framing_err, overrun_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_datapath.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_datapath : line synchronizer, bit timing counters, shifter
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_datapath import uart_pkg::*; #(
  parameter int WORD_SIZE     = UART_WORD_SIZE,
  parameter int CLKS_PER_BIT  = UART_CLKS_PER_BIT,
  parameter int CNT_WIDTH     = $clog2(CLKS_PER_BIT),
  parameter int BIT_CNT_WIDTH = $clog2(WORD_SIZE + 1)
) (
  input  wire                  clk,
  input  wire                  rst_b,
  input  wire                  serial_in_i,
  input  wire                  clear_cnt_i,
  input  wire                  shift_i,
  input  wire                  load_i,
  input  wire                  ack_i,
  output logic                 rxs_o,
  output logic                 cnt_half_o,
  output logic                 cnt_full_o,
  output logic                 bc_done_o,
  output logic [WORD_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o
);

  localparam logic [CNT_WIDTH-1:0]     CNT_HALF = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_WIDTH-1:0]     CNT_FULL = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] BC_LAST  = BIT_CNT_WIDTH'(WORD_SIZE - 1);

  logic                     sync1_q;
  logic                     rxs_q;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_WIDTH-1:0] bc_q, bc_d;
  logic [WORD_SIZE-1:0]     shreg_q, shreg_d;
  logic [WORD_SIZE-1:0]     rx_data_q;
  logic                     rx_valid_q, rx_valid_d;

  assign cnt_full_o = (cnt_q == CNT_FULL);
  assign cnt_half_o = (cnt_q == CNT_HALF);
  // Asserted while the final data bit is pending, so the FSM leaves DATA
  // on the same edge that bc reaches WORD_SIZE.
  assign bc_done_o  = (bc_q == BC_LAST);

  assign cnt_d      = (clear_cnt_i || cnt_full_o) ? '0 : cnt_q + 1'b1;
  assign bc_d       = clear_cnt_i ? '0 : (shift_i ? bc_q + 1'b1 : bc_q);
  assign shreg_d    = shift_i ? {rxs_q, shreg_q[WORD_SIZE-1:1]} : shreg_q;
  assign rx_valid_d = load_i | (rx_valid_q & ~ack_i);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      cnt_q      <= '0;
      bc_q       <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sync1_q    <= serial_in_i;
      rxs_q      <= sync1_q;
      cnt_q      <= cnt_d;
      bc_q       <= bc_d;
      shreg_q    <= shreg_d;
      rx_valid_q <= rx_valid_d;
      if (load_i) rx_data_q <= shreg_q;
    end
  end

  assign rxs_o      = rxs_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx : UART receiver, mid-bit sampling, valid/ack host handshake
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx import uart_pkg::*; #(
  parameter int WORD_SIZE     = UART_WORD_SIZE,
  parameter int CLKS_PER_BIT  = UART_CLKS_PER_BIT,
  parameter int CNT_WIDTH     = $clog2(CLKS_PER_BIT),
  parameter int BIT_CNT_WIDTH = $clog2(WORD_SIZE + 1)
) (
  input  wire      clk,
  input  wire      rst_b,
  uart_rx_if.slave bus
);

  uart_state_e          state_q;
  logic                 busy_q;
  logic                 framing_err_q;
  logic                 overrun_err_q;

  logic                 rxs, cnt_half, cnt_full, bc_done;
  logic                 clear_cnt, shift, load;
  logic                 rx_valid;
  logic [WORD_SIZE-1:0] rx_data;

  uart_rx_datapath #(
    .WORD_SIZE     (WORD_SIZE),
    .CLKS_PER_BIT  (CLKS_PER_BIT),
    .CNT_WIDTH     (CNT_WIDTH),
    .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst_b       (rst_b),
    .serial_in_i (bus.serial_in),
    .clear_cnt_i (clear_cnt),
    .shift_i     (shift),
    .load_i      (load),
    .ack_i       (bus.rx_ack),
    .rxs_o       (rxs),
    .cnt_half_o  (cnt_half),
    .cnt_full_o  (cnt_full),
    .bc_done_o   (bc_done),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid)
  );

  always_comb begin
    clear_cnt = 1'b0;
    shift     = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE, BREAK: clear_cnt = 1'b1;
      START:       clear_cnt = cnt_half;
      DATA:        shift     = cnt_full;
      STOP: begin
        clear_cnt = cnt_full;
        load      = cnt_full & rxs;
      end
      default:     clear_cnt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      case (state_q)
        IDLE: if (!rxs) begin
          state_q <= START;
          busy_q  <= 1'b1;
        end
        START: if (cnt_half) begin
          if (rxs) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (shift && bc_done) state_q <= STOP;
        STOP: if (cnt_full) begin
          if (rxs) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            overrun_err_q <= rx_valid & ~bus.rx_ack;
          end else begin
            state_q       <= BREAK;
            framing_err_q <= 1'b1;
          end
        end
        // Stay here until the line returns high so a held-low line never
        // looks like a fresh start bit.
        BREAK: if (rxs) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.framing_err = framing_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx at default parameters
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx;

  localparam int WS  = 8;
  localparam int CPB = 16;

  logic clk;
  logic rst_b;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   t_start;
  int   ovr_cnt;
  int   fe_cnt;
  int   n_pop;
  bit   fe_seen;
  bit   busy_seen;
  bit   prev_busy;
  logic [WS-1:0] sb[$];

  uart_rx_if #(.WORD_SIZE(WS)) bus ();

  uart_rx #(
    .WORD_SIZE    (WS),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Serialize one frame starting right after a rising edge; the line is
  // left at the stop-bit level on return.
  task automatic send_frame(input logic [WS-1:0] d, input bit good, input bit push);
    logic [WS+1:0] f;
    f = {good, d, 1'b0};
    if (push) sb.push_back(d);
    @(posedge clk); #1;
    t_start = cyc;
    for (int i = 0; i < WS + 2; i++) begin
      bus.serial_in = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1 bus.rx_ack = 1'b1;
    @(posedge clk); #1 bus.rx_ack = 1'b0;
  endtask

  // A word is delivered whenever busy drops with rx_valid set, except on
  // the exit from a framing error or a reset.
  initial begin
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.overrun_err) ovr_cnt++;
      if (bus.framing_err) begin
        fe_cnt++;
        fe_seen = 1'b1;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (!rst_b) fe_seen = 1'b0;
      else if (prev_busy && !bus.busy) begin
        if (fe_seen) fe_seen = 1'b0;
        else if (bus.rx_valid) begin
          check_eq("sb_pending", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            check_eq("sb_data", bus.rx_data, sb.pop_front());
            n_pop++;
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    bit ok;
    int lat, o0, f0, p0;
    logic [WS-1:0] d;

    n_checks = 0; n_errors = 0; cyc = 0;
    ovr_cnt = 0; fe_cnt = 0; n_pop = 0; fe_seen = 0; busy_seen = 0;
    rst_b = 1'b0;
    bus.serial_in = 1'b1;
    bus.rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data", bus.rx_data, 0);
    check_eq("rst_valid", bus.rx_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_ferr", bus.framing_err, 0);
    check_eq("rst_oerr", bus.overrun_err, 0);
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (4) @(posedge clk);
    check_eq("idle_busy", bus.busy, 0);

    // Latency and basic handshake
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        wait_valid(400, ok);
        lat = cyc - t_start;
      end
    join
    check_eq("a5_seen", ok, 1);
    check_eq("a5_latency", lat, 155);
    check_eq("a5_data", bus.rx_data, 8'hA5);
    check_eq("a5_hold_valid", bus.rx_valid, 1);
    ack_pulse();
    @(negedge clk);
    check_eq("a5_ack_clear", bus.rx_valid, 0);
    ack_pulse();
    @(negedge clk);
    check_eq("ack_when_empty", bus.rx_valid, 0);

    // Glitch rejection
    busy_seen = 1'b0;
    @(posedge clk); #1 bus.serial_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.serial_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_eq("glitch_busy_pulse", busy_seen, 1);
    check_eq("glitch_idle", bus.busy, 0);
    check_eq("glitch_valid", bus.rx_valid, 0);
    check_eq("glitch_ferr_cnt", fe_cnt, 0);
    check_eq("glitch_oerr_cnt", ovr_cnt, 0);

    // Framing error, held-low line, then recovery
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1 check_eq("break_busy", bus.busy, 1);
    bus.serial_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("ferr_pulses", fe_cnt - f0, 1);
    check_eq("ferr_valid", bus.rx_valid, 0);
    check_eq("ferr_data_kept", bus.rx_data, 8'hA5);
    check_eq("break_exit", bus.busy, 0);
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      wait_valid(400, ok);
    join
    check_eq("5a_seen", ok, 1);
    check_eq("5a_data", bus.rx_data, 8'h5A);
    ack_pulse();

    // Overrun
    o0 = ovr_cnt;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    check_eq("ovr_pulses", ovr_cnt - o0, 1);
    check_eq("ovr_valid", bus.rx_valid, 1);
    check_eq("ovr_data", bus.rx_data, 8'h80);

    // Ack on the exact completion cycle
    o0 = ovr_cnt;
    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (154) @(posedge clk);
        #1 bus.rx_ack = 1'b1;
        @(posedge clk); #1 bus.rx_ack = 1'b0;
      end
    join
    check_eq("sim_ack_valid", bus.rx_valid, 1);
    check_eq("sim_ack_data", bus.rx_data, 8'hC3);
    check_eq("sim_ack_no_ovr", ovr_cnt - o0, 0);

    // Reset in the middle of a data phase
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        repeat (60) @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_data", bus.rx_data, 0);
        check_eq("mid_rst_valid", bus.rx_valid, 0);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_errs", {bus.framing_err, bus.overrun_err}, 0);
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
      end
    join
    check_eq("post_rst_idle", bus.busy, 0);
    fork
      send_frame(8'h42, 1'b1, 1'b1);
      wait_valid(400, ok);
    join
    check_eq("42_seen", ok, 1);
    check_eq("42_data", bus.rx_data, 8'h42);
    ack_pulse();

    // Loopback of random words
    o0 = ovr_cnt;
    f0 = fe_cnt;
    p0 = n_pop;
    for (int k = 0; k < 256; k++) begin
      d = WS'($urandom_range(0, 255));
      send_frame(d, 1'b1, 1'b1);
      ack_pulse();
    end
    repeat (4) @(posedge clk);
    check_eq("loop_words", n_pop - p0, 256);
    check_eq("loop_sb_empty", sb.size(), 0);
    check_eq("loop_no_ovr", ovr_cnt - o0, 0);
    check_eq("loop_no_ferr", fe_cnt - f0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
